// File: rtl/mux_2_1.sv
// Registered 2-to-1 selector: out <= sel ? in_1 : in_2, one cycle latency.
// Define MUX2_1_STATS_EN to add the saturating select-change counter sel_cnt.
module mux_2_1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   input  logic             sel,
   output logic [WIDTH-1:0] out
`ifdef MUX2_1_STATS_EN
   ,
   output logic [CNT_W-1:0] sel_cnt
`endif
);

   if (WIDTH < 1) begin : g_bad_width
      $error("mux_2_1: WIDTH must be at least 1");
   end

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("mux_2_1: CNT_W must be at least 1");
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         out <= '0;
      end else begin
         out <= sel ? in_1 : in_2;
      end
   end

`ifdef MUX2_1_STATS_EN
   logic sel_d;
   logic sel_chg;
   logic cnt_full;

   assign sel_chg  = sel ^ sel_d;
   assign cnt_full = &sel_cnt;

   // Counter holds at all-ones instead of wrapping.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sel_d   <= 1'b0;
         sel_cnt <= '0;
      end else begin
         sel_d <= sel;
         if (sel_chg && !cnt_full) begin
            sel_cnt <= sel_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mux_2_1.sv
// Directed and random checks for mux_2_1 (WIDTH 1 and WIDTH 8 instances).
// Counter checks compile only when MUX2_1_STATS_EN is defined.
module tb_mux_2_1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a1, b1, s1;
   logic [7:0] a8, b8;
   logic       s8;
   logic       o1;
   logic [7:0] o8;
`ifdef MUX2_1_STATS_EN
   logic [1:0]  cnt1;
   logic [15:0] cnt8;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   mux_2_1 #(.WIDTH(1), .CNT_W(2)) u_dut1 (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .in_1      (a1),
      .in_2      (b1),
      .sel       (s1),
      .out       (o1)
`ifdef MUX2_1_STATS_EN
      ,
      .sel_cnt   (cnt1)
`endif
   );

   mux_2_1 #(.WIDTH(8)) u_dut8 (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .in_1      (a8),
      .in_2      (b8),
      .sel       (s8),
      .out       (o8)
`ifdef MUX2_1_STATS_EN
      ,
      .sel_cnt   (cnt8)
`endif
   );

   typedef struct {
      logic       rst_n;
      logic       sel;
      logic [7:0] in_1;
      logic [7:0] in_2;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic       ra, rb, rs, e1;
      logic [7:0] ra8, rb8, e8;
      logic       rs8;

      rst_n = 1'b0;
      a1 = 1'b1; b1 = 1'b1; s1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
      #2;

      // Reset held for three edges with all inputs high.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_out1", 32'(o1), 32'h0);
         chk("rst_out8", 32'(o8), 32'h0);
`ifdef MUX2_1_STATS_EN
         chk("rst_cnt1", 32'(cnt1), 32'h0);
         chk("rst_cnt8", 32'(cnt8), 32'h0);
`endif
      end

      // Basic selection, WIDTH = 1.
      rst_n = 1'b1;
      a1 = 1'b1; b1 = 1'b0; s1 = 1'b1;
      step();
      chk("basic_sel1", 32'(o1), 32'h1);
      s1 = 1'b0;
      step();
      chk("basic_sel0", 32'(o1), 32'h0);
      a1 = 1'b0; b1 = 1'b1;
      step();
      chk("basic_swap", 32'(o1), 32'h1);

      // Table vectors on the WIDTH = 8 instance.
      vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5};
      vecs[1] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'h3C};
      vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF};
      vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00};
      vecs[4] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 8'h5A};
      vecs[5] = '{1'b1, 1'b1, 8'h5A, 8'h5A, 8'h5A};
      vecs[6] = '{1'b1, 1'b1, 8'h80, 8'h01, 8'h80};
      vecs[7] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h01};
      vecs[8] = '{1'b0, 1'b1, 8'hC3, 8'h7E, 8'h00};
      vecs[9] = '{1'b1, 1'b0, 8'hC3, 8'h7E, 8'h7E};
      for (int i = 0; i < 10; i++) begin
         rst_n = vecs[i].rst_n;
         s8    = vecs[i].sel;
         a8    = vecs[i].in_1;
         b8    = vecs[i].in_2;
         step();
         chk($sformatf("vec%0d", i), 32'(o8), 32'(vecs[i].exp));
      end

      // Mid-stream reset pulse.
      rst_n = 1'b1;
      a8 = 8'hA5; b8 = 8'h00; s8 = 1'b1;
      step();
      chk("mid_pre", 32'(o8), 32'hA5);
      rst_n = 1'b0;
      step();
      chk("mid_rst", 32'(o8), 32'h00);
      rst_n = 1'b1;
      step();
      chk("mid_rel", 32'(o8), 32'hA5);

      // Inputs changed between edges: only edge values matter.
      a8 = 8'h11; s8 = 1'b0; b8 = 8'h22;
      #3;
      a8 = 8'h33; s8 = 1'b1;
      step();
      chk("between", 32'(o8), 32'h33);

      // Random stimulus against a reference selection.
      for (int i = 0; i < 200; i++) begin
         ra  = 1'($urandom);
         rb  = 1'($urandom);
         rs  = 1'($urandom);
         ra8 = 8'($urandom);
         rb8 = 8'($urandom);
         rs8 = 1'($urandom);
         a1 = ra;  b1 = rb;  s1 = rs;
         a8 = ra8; b8 = rb8; s8 = rs8;
         e1 = rs ? ra : rb;
         e8 = rs8 ? ra8 : rb8;
         step();
         chk("rand1", 32'(o1), 32'(e1));
         chk("rand8", 32'(o8), 32'(e8));
      end

`ifdef MUX2_1_STATS_EN
      // Saturating counter, CNT_W = 2.
      rst_n = 1'b0;
      s1 = 1'b0;
      step();
      chk("cnt_rst", 32'(cnt1), 32'h0);
      rst_n = 1'b1;
      step();
      chk("cnt_first0", 32'(cnt1), 32'h0);
      for (int i = 0; i < 5; i++) begin
         s1 = ~s1;
         step();
         chk($sformatf("cnt_tog%0d", i), 32'(cnt1),
             (i < 3) ? 32'(i + 1) : 32'h3);
      end
      step();
      chk("cnt_hold", 32'(cnt1), 32'h3);

      // A 1 on sel in the first cycle after reset counts once.
      rst_n = 1'b0;
      s1 = 1'b0;
      step();
      rst_n = 1'b1;
      s1 = 1'b1;
      step();
      chk("cnt_first1", 32'(cnt1), 32'h1);
      step();
      chk("cnt_steady", 32'(cnt1), 32'h1);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
